rtx_frame_scheduler: RTL
========================

Name: rtx_frame_scheduler

Overview:
- Sequences the ray tracer over one frame at a time.
- On a frame request from the display side, it freezes the light position for the whole frame and issues every pixel coordinate in raster order to the ray tracer over a valid/ready handshake.
- Tracks in-flight pixels with a credit counter and pulses frame done once all results have retired into the framebuffer.
- Sits between the light-position input / VGA frame timing and the ray tracer.

Parameters:
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- LOC_WIDTH, 10, width of each light coordinate; equals the shared LOC_WIDTH constant.
- MAX_OUT, 8, maximum in-flight pixel jobs (range 1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_req_i  in  1  single-cycle frame start request (vsync edge).
- l_loc_x_i / l_loc_y_i / l_loc_z_i  in  LOC_WIDTH each  incoming light position.
- l_loc_vld_i  in  1  light position valid.
- job_x_o  out  clog2(H_RES)  pixel column.
- job_y_o  out  clog2(V_RES)  pixel row.
- job_vld_o  out  1  job valid.
- job_rdy_i  in  1  ray tracer accepts job.
- frm_l_x_o / frm_l_y_o / frm_l_z_o  out  LOC_WIDTH each  light position frozen for the current frame.
- res_vld_i  in  1  one pixel result retired.
- busy_o  out  1  high when the FSM is not IDLE.
- frame_done_o  out  1  one-cycle pulse at frame completion.
- frame_cnt_o  out  16  completed frames, wraps.
- overrun_cnt_o  out  8  dropped frame requests, saturating.
- err_o  out  1  sticky; set on a result with nothing outstanding.

Behaviour:
- Reset: all outputs 0, FSM IDLE, shadow and frame light registers 0, x = y = 0, outstanding = 0.
- Shadow light register: loads l_loc_*_i on any cycle with l_loc_vld_i = 1.
- FSM states: IDLE, LATCH, ISSUE, DRAIN, DONE.
- IDLE: frame_req_i = 1 -> LATCH next cycle.
- LATCH (1 cycle):
  - frm_l_*_o <= shadow; if l_loc_vld_i = 1 in this cycle, frm_l_*_o <= l_loc_*_i instead (bypass).
  - x = y = 0; -> ISSUE.
- frm_l_*_o changes only in LATCH; it is stable from ISSUE through DONE.
- ISSUE:
  - job_vld_o = (outstanding < MAX_OUT).
  - Transfer occurs when job_vld_o and job_rdy_i are both 1.
  - Once job_vld_o is asserted, it and job_x_o/job_y_o stay stable until the transfer completes. Credits only increase while a job is pending, so this holds.
  - On transfer: x+1; at x = H_RES-1, x wraps to 0 and y+1.
  - Transfer of (H_RES-1, V_RES-1) -> DRAIN; job_vld_o = 0 from the next cycle.
- Outstanding counter:
  - Increments on transfer and decrements on res_vld_i; both in the same cycle leaves it unchanged.
  - res_vld_i with outstanding = 0 and no transfer in the same cycle: counter held, err_o set (cleared only by reset).
  - Width is clog2(MAX_OUT+1).
- DRAIN: outstanding = 0 -> DONE. If the last result arrives in the same cycle the last job issues, the FSM still waits for that result.
- DONE (1 cycle): frame_done_o = 1, frame_cnt_o + 1 (wraps), -> IDLE.
- frame_req_i in any state other than IDLE (including DONE): request dropped, overrun_cnt_o + 1, saturating at 255.
- Latency from frame_req_i to first job_vld_o: 2 cycles (IDLE -> LATCH -> ISSUE).
- Minimum frame time is H_RES*V_RES + 3 cycles, assuming job_rdy_i is always 1 and results arrive with no delay.
- Reset asserted mid-frame: immediate return to IDLE, job_vld_o drops asynchronously, counters cleared. Results from in-flight jobs arriving after release set err_o; the integrator is responsible for resetting the ray tracer together with this block.

Decomposition:
- rtx_pkg holds:
  - the sched_state_t enum (IDLE, LATCH, ISSUE, DRAIN, DONE);
  - LOC_WIDTH, H_RES_DEF, V_RES_DEF, MAX_OUT_DEF;
  - the X_W/Y_W width functions.
- One sub-module: raster_counter. It takes H_RES/V_RES parameters, clear and advance inputs, and has x, y and last outputs.
- Credit counter and FSM stay in the top module.

Test Plan:
- Frame with H_RES=4, V_RES=3, MAX_OUT=8, job_rdy_i=1 and results returned 1 cycle after issue, frame_req_i pulsed at t0:
  - job_vld_o first high at t0+2;
  - 12 jobs issued in order (0,0),(1,0)..(3,2);
  - frame_done_o pulses once; frame_cnt_o = 1.
- Light freeze: shadow = (5,6,7); frame_req_i; then l_loc_vld_i with (9,9,9) during ISSUE -> frm_l_*_o stays (5,6,7) for the whole frame and becomes (9,9,9) on the next frame.
- LATCH bypass: l_loc_vld_i with (1,2,3) in the LATCH cycle -> frm_l_*_o = (1,2,3).
- Backpressure and credits:
  - MAX_OUT=2, results withheld -> exactly 2 transfers, then job_vld_o = 0;
  - one res_vld_i pulse -> job_vld_o reasserts next cycle;
  - job_rdy_i toggled randomly -> coordinates never change while job_vld_o=1 and job_rdy_i=0.
- Overrun and error:
  - 3 frame_req_i pulses during ISSUE/DONE -> overrun_cnt_o = 3;
  - res_vld_i in IDLE -> err_o = 1 and stays 1.
- Reset mid-frame: rst_n low at pixel 5 -> busy_o and job_vld_o = 0 without waiting for a clock edge; after release a new frame_req_i restarts at (0,0) with frame_cnt_o = 0.

Source files
------------

// File: rtl/rtx_pkg.sv
// rtx_pkg: shared constants, scheduler state encoding and raster width helpers
package rtx_pkg;
  localparam int LOC_WIDTH   = 10;
  localparam int H_RES_DEF   = 640;
  localparam int V_RES_DEF   = 480;
  localparam int MAX_OUT_DEF = 8;
  typedef enum logic [2:0] {IDLE, LATCH, ISSUE, DRAIN, DONE} sched_state_t;
  typedef struct packed {
    logic [LOC_WIDTH-1:0] x;
    logic [LOC_WIDTH-1:0] y;
    logic [LOC_WIDTH-1:0] z;
  } loc_t;
  function automatic int X_W(input int h_res);
    return (h_res > 1) ? $clog2(h_res) : 1;
  endfunction
  function automatic int Y_W(input int v_res);
    return (v_res > 1) ? $clog2(v_res) : 1;
  endfunction
endpackage

// File: rtl/rtx_frame_scheduler_raster_counter.sv
// raster_counter: raster-order pixel coordinate generator
//   clr_i  : restart at (0,0)
//   adv_i  : step to the next pixel in raster order
//   x_o/y_o: current pixel; last_o: current pixel is the final one of the frame
module raster_counter import rtx_pkg::*; #(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   adv_i,
  output logic [X_W(H_RES)-1:0]  x_o,
  output logic [Y_W(V_RES)-1:0]  y_o,
  output logic                   last_o
);
  localparam int XW = X_W(H_RES);
  localparam int YW = Y_W(V_RES);
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_end;
  assign x_end  = x_q == XW'(H_RES - 1);
  assign last_o = x_end && (y_q == YW'(V_RES - 1));
  assign x_o    = x_q;
  assign y_o    = y_q;
  always_comb begin
    x_d = clr_i ? '0 : adv_i ? (x_end ? '0 : x_q + 1'b1) : x_q;
    y_d = (clr_i || (adv_i && last_o)) ? '0 : (adv_i && x_end) ? y_q + 1'b1 : y_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
endmodule

// File: rtl/rtx_frame_scheduler.sv
// rtx_frame_scheduler: per-frame pixel job sequencer for the ray tracer
//   frame_req_i            : frame start request (vsync edge)
//   l_loc_*_i/l_loc_vld_i  : live light position, captured into a shadow register
//   job_*_o/job_rdy_i      : raster-order pixel jobs, valid/ready handshake
//   frm_l_*_o              : light position frozen for the current frame
//   res_vld_i              : one pixel result retired
//   busy_o/frame_done_o    : status; frame_cnt_o/overrun_cnt_o/err_o : counters and sticky error
module rtx_frame_scheduler import rtx_pkg::*; #(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_req_i,
  input  logic [LOC_WIDTH-1:0]  l_loc_x_i,
  input  logic [LOC_WIDTH-1:0]  l_loc_y_i,
  input  logic [LOC_WIDTH-1:0]  l_loc_z_i,
  input  logic                  l_loc_vld_i,
  output logic [X_W(H_RES)-1:0] job_x_o,
  output logic [Y_W(V_RES)-1:0] job_y_o,
  output logic                  job_vld_o,
  input  logic                  job_rdy_i,
  output logic [LOC_WIDTH-1:0]  frm_l_x_o,
  output logic [LOC_WIDTH-1:0]  frm_l_y_o,
  output logic [LOC_WIDTH-1:0]  frm_l_z_o,
  input  logic                  res_vld_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [15:0]           frame_cnt_o,
  output logic [7:0]            overrun_cnt_o,
  output logic                  err_o
);
  localparam int OW = $clog2(MAX_OUT + 1);
  sched_state_t  state_q, state_d;
  loc_t          l_in, sh_q, frm_q;
  logic [OW-1:0] out_q, out_d;
  logic [15:0]   frame_cnt_q;
  logic [7:0]    ovr_q;
  logic          err_q, xfer, last;
  assign l_in          = {l_loc_x_i, l_loc_y_i, l_loc_z_i};
  // Derived from registered state only, so it drops as soon as reset is asserted.
  assign job_vld_o     = (state_q == ISSUE) && (out_q < OW'(MAX_OUT));
  assign xfer          = job_vld_o && job_rdy_i;
  assign busy_o        = state_q != IDLE;
  assign frame_done_o  = state_q == DONE;
  assign frm_l_x_o     = frm_q.x;
  assign frm_l_y_o     = frm_q.y;
  assign frm_l_z_o     = frm_q.z;
  assign frame_cnt_o   = frame_cnt_q;
  assign overrun_cnt_o = ovr_q;
  assign err_o         = err_q;
  raster_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_raster (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == LATCH),
    .adv_i  (xfer),
    .x_o    (job_x_o),
    .y_o    (job_y_o),
    .last_o (last)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = frame_req_i ? LATCH : IDLE;
      LATCH:   state_d = ISSUE;
      ISSUE:   state_d = (xfer && last) ? DRAIN : ISSUE;
      // Uses the registered count, so a result landing with the last issue is still awaited.
      DRAIN:   state_d = (out_q == '0) ? DONE : DRAIN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // A result with nothing outstanding is held at zero rather than underflowing.
  always_comb out_d = (xfer && !res_vld_i) ? out_q + 1'b1 :
                      (!xfer && res_vld_i && out_q != '0) ? out_q - 1'b1 : out_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q        <= '0;
      frm_q       <= '0;
      out_q       <= '0;
      frame_cnt_q <= '0;
      ovr_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      if (l_loc_vld_i) sh_q <= l_in;
      if (state_q == LATCH) frm_q <= l_loc_vld_i ? l_in : sh_q;
      out_q <= out_d;
      if (state_q == DONE) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (frame_req_i && state_q != IDLE && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
      if (res_vld_i && !xfer && out_q == '0) err_q <= 1'b1;
    end
  end
endmodule
